// File: rtl/stream_rx_if.sv
// Stream-in and register-bus signals for stream_rx, grouped with source/sink views.
interface stream_rx_if;
    logic [7:0]  i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_tdata, i_tlast, i_tvalid, i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb,
        input  o_tready, o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb,
        output o_tready, o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/stream_rx.sv
// Byte-stream receive FIFO with packet/byte accounting, drained and controlled
// through a four-register single-cycle-ack bus.
module stream_rx #(
    parameter int DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    stream_rx_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    pkt_q, pkt_d;
    logic [31:0]   byte_cnt_q, byte_cnt_d;
    logic          ack_q, ack_d;

    logic          empty, full, push, pop, flush, clr;
    logic          rd_ack, wr_ack;
    logic [8:0]    head;
    logic [31:0]   status;

    // Packet count saturates at 255 and floors at 0; push and pop together cancel.
    function automatic logic [7:0] pkt_step(input logic [7:0] cur, input logic inc,
                                            input logic dec);
        if (inc && !dec) return (cur == 8'hFF) ? cur : cur + 8'd1;
        if (dec && !inc) return (cur == 8'h00) ? cur : cur - 8'd1;
        return cur;
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    assign bus.o_tready = !full;
    assign push         = bus.i_tvalid && !full;

    // Bus side effects commit at the end of the ack cycle.
    assign rd_ack = ack_q && !bus.i_wb_we;
    assign wr_ack = ack_q && bus.i_wb_we;
    assign pop    = rd_ack && (bus.i_wb_adr == 2'd0) && !empty;
    assign flush  = wr_ack && (bus.i_wb_adr == 2'd2) && bus.i_wb_dat[0];
    assign clr    = wr_ack && (bus.i_wb_adr == 2'd3);

    assign status = {6'b0, full, empty, pkt_q, 16'(cnt_q)};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        pkt_d      = pkt_step(pkt_q, push && bus.i_tlast, pop && head[8]);
        byte_cnt_d = clr ? 32'd0 : byte_cnt_q + 32'(push);
        ack_d      = bus.i_wb_stb && !ack_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;

        // A byte landing on the flush cycle is dropped along with the contents.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            pkt_d    = '0;
        end
    end

    always_comb begin
        bus.o_wb_rdt = 32'd0;
        if (rd_ack) begin
            case (bus.i_wb_adr)
                2'd0:    bus.o_wb_rdt = empty ? 32'd0 : {1'b1, 22'b0, head};
                2'd1:    bus.o_wb_rdt = status;
                2'd3:    bus.o_wb_rdt = byte_cnt_q;
                default: bus.o_wb_rdt = 32'd0;
            endcase
        end
    end

    assign bus.o_wb_ack = ack_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            pkt_q      <= '0;
            byte_cnt_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            pkt_q      <= pkt_d;
            byte_cnt_q <= byte_cnt_d;
            ack_q      <= ack_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.i_tlast, bus.i_tdata};
    end
endmodule
